// File: rtl/cr2_toggle_counter.sv
// Modulo-MODULUS up/down counter whose state is written only as Q <= Q ^ T.
// Optional build macro CR2_TCNT_SATURATE_EN: block steps at the terminal value instead of wrapping.
module cr2_toggle_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 2**WIDTH
) (
  input  logic             C,
  input  logic             R,
  input  logic             CE,
  input  logic             UP,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] T,
  output logic             WRAP
);

  localparam int              TERM_I = MODULUS - 1;
  localparam logic [WIDTH-1:0] TERM  = TERM_I[WIDTH-1:0];
  localparam bit              POW2   = (MODULUS == (2**WIDTH));
`ifdef CR2_TCNT_SATURATE_EN
  localparam bit              SATURATE = 1'b1;
`else
  localparam bit              SATURATE = 1'b0;
`endif

  generate
    if (WIDTH < 1 || MODULUS < 2 || MODULUS > 2**WIDTH) begin : g_bad_param
      $error("cr2_toggle_counter: illegal WIDTH/MODULUS combination");
    end
  endgenerate

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;

  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_dec;
  logic             w_at_top;
  logic             w_at_bot;
  logic             w_at_edge;
  logic [WIDTH-1:0] w_ld_val;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_next;
  logic             w_wrap_next;

  // Power-of-two ranges detect the terminal from the carry/borrow bit of a WIDTH+1 adder.
  assign w_inc     = {1'b0, r_q} + {{WIDTH{1'b0}}, 1'b1};
  assign w_dec     = {1'b0, r_q} - {{WIDTH{1'b0}}, 1'b1};
  assign w_at_top  = POW2 ? w_inc[WIDTH] : (r_q == TERM);
  assign w_at_bot  = POW2 ? w_dec[WIDTH] : (r_q == {WIDTH{1'b0}});
  assign w_at_edge = UP ? w_at_top : w_at_bot;
  assign w_ld_val  = (D > TERM) ? TERM : D;

  // Value reached by one enabled step in the current direction.
  always_comb begin
    w_step = r_q;
    if (UP) begin
      if (w_at_top) begin
        w_step = SATURATE ? r_q : {WIDTH{1'b0}};
      end else begin
        w_step = w_inc[WIDTH-1:0];
      end
    end else begin
      if (w_at_bot) begin
        w_step = SATURATE ? r_q : TERM;
      end else begin
        w_step = w_dec[WIDTH-1:0];
      end
    end
  end

  // Next-state selection with priority R > LD > CE.
  always_comb begin
    w_next      = r_q;
    w_wrap_next = 1'b0;
    if (R) begin
      w_next      = {WIDTH{1'b0}};
      w_wrap_next = 1'b0;
    end else if (LD) begin
      w_next      = w_ld_val;
      w_wrap_next = 1'b0;
    end else if (CE) begin
      w_next      = w_step;
      w_wrap_next = w_at_edge;
    end else begin
      w_next      = r_q;
      w_wrap_next = 1'b0;
    end
  end

  assign T = r_q ^ w_next;

  // Toggle-form state update; reset clears Q through T = Q, so only WRAP needs a reset branch.
  always_ff @(posedge C) begin
    r_q <= r_q ^ T;
    if (R) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_wrap_next;
    end
  end

  assign Q    = r_q;
  assign WRAP = r_wrap;

endmodule
